// File: rtl/line_writeback_serializer_pkg.sv
// Shared types for the line writeback path: cache geometry, beat width and
// the writeback FSM state encoding.
package line_writeback_serializer_pkg;

    localparam int unsigned WORD_WIDTH     = 16;
    localparam int unsigned WORDS_PER_LINE = 8;
    localparam int unsigned LINE_WIDTH     = WORD_WIDTH * WORDS_PER_LINE;
    localparam int unsigned BEAT_WIDTH     = $clog2(WORDS_PER_LINE);

    typedef logic [WORD_WIDTH-1:0] lc3b_word;
    typedef logic [2:0]            cache_index;
    typedef logic [8:0]            cache_tag;
    typedef logic [LINE_WIDTH-1:0] cache_line;
    typedef logic [BEAT_WIDTH-1:0] beat_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } wb_state_t;

    // Byte address of one beat: word-aligned, beat selects the word in the line.
    function automatic lc3b_word beat_address(cache_tag tag, cache_index index, beat_t beat);
        return {tag, index, beat, 1'b0};
    endfunction

endpackage

// File: rtl/line_writeback_serializer_word_mux.sv
// Selects one memory word out of a cache line by word index.
// Purely combinational so the read-hit path can share it.
module line_word_mux #(
    parameter int unsigned WORD_WIDTH     = 16,
    parameter int unsigned WORDS_PER_LINE = 8
) (
    input  logic [WORD_WIDTH*WORDS_PER_LINE-1:0] line_i,
    input  logic [$clog2(WORDS_PER_LINE)-1:0]    sel_i,
    output logic [WORD_WIDTH-1:0]                word_o
);

    // Word k occupies bits [WORD_WIDTH*k +: WORD_WIDTH].
    always_comb begin
        word_o = line_i[sel_i*WORD_WIDTH +: WORD_WIDTH];
    end

endmodule

// File: rtl/line_writeback_serializer.sv
// Evicts one cache line: reads it from the data array by index, then writes
// it to memory as eight word beats, each with its own write/resp handshake.
module line_writeback_serializer
    import line_writeback_serializer_pkg::*;
#(
    parameter int unsigned WORD_WIDTH     = 16,
    parameter int unsigned WORDS_PER_LINE = 8
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               wb_start,
    input  logic [2:0]                         wb_index,
    input  logic [8:0]                         wb_tag,
    output logic                               wb_busy,
    output logic                               wb_done,
    output logic [2:0]                         arr_index,
    input  logic [WORD_WIDTH*WORDS_PER_LINE-1:0] arr_dataout,
    output logic [15:0]                        mem_address,
    output logic [WORD_WIDTH-1:0]              mem_wdata,
    output logic                               mem_write,
    input  logic                               mem_resp
);

    localparam int unsigned LW = WORD_WIDTH * WORDS_PER_LINE;
    localparam beat_t LAST_BEAT = beat_t'(WORDS_PER_LINE - 1);

    wb_state_t   state_q;
    cache_index  index_q;
    cache_tag    tag_q;
    logic [LW-1:0] line_q;
    beat_t       beat_q;
    logic        write_q;
    logic        busy_q;
    logic        done_q;

    // Writeback sequencer: all outputs are registered here, so nothing at the
    // ports depends combinationally on wb_start or mem_resp.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            index_q <= '0;
            tag_q   <= '0;
            line_q  <= '0;
            beat_q  <= '0;
            write_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (wb_start) begin
                        index_q <= wb_index;
                        tag_q   <= wb_tag;
                        busy_q  <= 1'b1;
                        state_q <= READ;
                    end
                end
                READ: begin
                    line_q  <= arr_dataout;
                    beat_q  <= '0;
                    write_q <= 1'b1;
                    state_q <= SEND;
                end
                SEND: begin
                    if (mem_resp) begin
                        if (beat_q == LAST_BEAT) begin
                            write_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    line_word_mux #(
        .WORD_WIDTH     (WORD_WIDTH),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_word_mux (
        .line_i (line_q),
        .sel_i  (beat_q),
        .word_o (mem_wdata)
    );

    // Port views of the registered state.
    always_comb begin
        arr_index   = index_q;
        mem_address = beat_address(tag_q, index_q, beat_q);
        mem_write   = write_q;
        wb_busy     = busy_q;
        wb_done     = done_q;
    end

endmodule

// File: tb/tb_line_writeback_serializer.sv
// Self-checking bench for line_writeback_serializer: a position-based
// transfer model checked every cycle, plus literal beat/latency expectations.
module tb_line_writeback_serializer;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         wb_start;
    logic [2:0]   wb_index;
    logic [8:0]   wb_tag;
    logic         wb_busy;
    logic         wb_done;
    logic [2:0]   arr_index;
    logic [127:0] arr_dataout;
    logic [15:0]  mem_address;
    logic [15:0]  mem_wdata;
    logic         mem_write;
    logic         mem_resp;

    logic         dir_resp;
    logic         stall_resp;
    logic         stall_mode;
    logic         chk_on = 1'b0;

    logic [127:0] arr [8];
    logic [31:0]  obs [$];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign arr_dataout = arr[arr_index];
    assign mem_resp    = stall_mode ? stall_resp : dir_resp;

    line_writeback_serializer #(
        .WORD_WIDTH     (16),
        .WORDS_PER_LINE (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wb_start    (wb_start),
        .wb_index    (wb_index),
        .wb_tag      (wb_tag),
        .wb_busy     (wb_busy),
        .wb_done     (wb_done),
        .arr_index   (arr_index),
        .arr_dataout (arr_dataout),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_write   (mem_write),
        .mem_resp    (mem_resp)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transfer model: m_pos = -1 idle, 0 line read, 1..8 beat (m_pos-1), 9 done.
    int           m_pos;
    logic [2:0]   m_idx;
    logic [8:0]   m_tag;
    logic [127:0] m_line;
    logic         m_fresh;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pos   <= -1;
            m_idx   <= '0;
            m_tag   <= '0;
            m_line  <= '0;
            m_fresh <= 1'b1;
        end else if (m_pos == -1) begin
            if (wb_start) begin
                m_pos   <= 0;
                m_idx   <= wb_index;
                m_tag   <= wb_tag;
                m_fresh <= 1'b0;
            end
        end else if (m_pos == 0) begin
            m_line <= arr[m_idx];
            m_pos  <= 1;
        end else if (m_pos <= 8) begin
            if (mem_resp) m_pos <= m_pos + 1;
        end else begin
            m_pos <= -1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        int k;
        if (chk_on) begin
            k = m_pos - 1;
            chk("busy", wb_busy, m_pos >= 0);
            chk("done", wb_done, m_pos == 9);
            chk("mem_write", mem_write, (m_pos >= 1) && (m_pos <= 8));
            if (m_pos >= 1 && m_pos <= 8) begin
                chk("mem_address", mem_address, {m_tag, m_idx, 3'(k), 1'b0});
                chk("mem_wdata", mem_wdata, m_line[16*k +: 16]);
            end
            if (m_pos >= 0) chk("arr_index", arr_index, m_idx);
            if (m_fresh) begin
                chk("rst_arr_index", arr_index, 3'd0);
                chk("rst_mem_address", mem_address, 16'd0);
                chk("rst_mem_wdata", mem_wdata, 16'd0);
            end
        end
    end

    // Log of accepted beats {address, data}, sampled with pre-edge values.
    always @(posedge clk) begin
        if (reset_n && mem_write && mem_resp) obs.push_back({mem_address, mem_wdata});
    end

    // Slow memory: resp rises on the 3rd edge after each beat begins.
    initial begin
        int  s_cnt;
        logic acc;
        logic pre;
        stall_resp = 1'b0;
        s_cnt      = 0;
        forever begin
            @(posedge clk);
            acc = mem_write && mem_resp;
            pre = mem_write;
            #2;
            if (mem_write && (acc || !pre)) s_cnt = 0;
            else if (mem_write)             s_cnt++;
            else                            s_cnt = 0;
            stall_resp = mem_write && (s_cnt >= 3);
        end
    end

    task automatic start_wb(input logic [2:0] idx, input logic [8:0] tag);
        @(posedge clk); #2;
        wb_start = 1'b1;
        wb_index = idx;
        wb_tag   = tag;
        @(posedge clk); #2;
        wb_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit, output int n);
        bit seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < limit) begin
            @(negedge clk);
            n++;
            seen = wb_done;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s: wb_done not seen within %0d cycles", name, limit);
        end
    endtask

    task automatic chk_beats(input string name, input int base, input logic [15:0] addr0,
                             input logic [127:0] line);
        for (int k = 0; k < 8; k++) begin
            if (base + k < obs.size()) begin
                chk({name, "_addr"}, obs[base+k][31:16], addr0 + 16'(2*k));
                chk({name, "_data"}, obs[base+k][15:0], line[16*k +: 16]);
            end
        end
    endtask

    initial begin
        int n;
        int n2;
        wb_start   = 1'b0;
        wb_index   = '0;
        wb_tag     = '0;
        dir_resp   = 1'b0;
        stall_mode = 1'b0;
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++)
                arr[i][16*k +: 16] = 16'(16'h1000*i + 16'h0100*k + 16'h00C5);
        arr[5] = 128'h7777_6666_5555_4444_3333_2222_1111_0000;

        // Reset, then idle with resp toggling.
        #1 reset_n = 1'b0;
        #1;
        chk("reset_busy", wb_busy, 1'b0);
        chk("reset_done", wb_done, 1'b0);
        chk("reset_write", mem_write, 1'b0);
        chk("reset_addr", mem_address, 16'h0000);
        chk_on = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #2;
            dir_resp = ~dir_resp;
        end
        chk("idle_no_beats", obs.size(), 0);

        // Basic eviction, resp tied high.
        dir_resp = 1'b1;
        obs.delete();
        start_wb(3'd5, 9'h1A3);
        wait_done("basic", 40, n);
        chk("basic_latency", n, 10);
        chk("basic_count", obs.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < obs.size()) begin
                chk("basic_lit_addr", obs[k][31:16], 16'hD1D0 + 16'(2*k));
                chk("basic_lit_data", obs[k][15:0], 16'(16'h1111*k));
            end
        end

        // Stalled memory.
        stall_mode = 1'b1;
        obs.delete();
        start_wb(3'd7, 9'h123);
        wait_done("stall", 100, n);
        chk("stall_latency", n, 34);
        chk("stall_count", obs.size(), 8);
        chk_beats("stall", 0, 16'h91F0, arr[7]);
        stall_mode = 1'b0;

        // Requests during READ, SEND and DONE are ignored.
        dir_resp = 1'b1;
        obs.delete();
        @(posedge clk); #2;
        wb_start = 1'b1; wb_index = 3'd3; wb_tag = 9'h0AA;
        @(posedge clk); #2;
        wb_index = 3'd4; wb_tag = 9'h155;
        @(posedge clk); #2;
        wb_start = 1'b0;
        @(posedge clk); #2;
        wb_start = 1'b1; wb_index = 3'd6; wb_tag = 9'h0F0;
        @(posedge clk); #2;
        wb_start = 1'b0;
        wait_done("ignore", 40, n);
        wb_start = 1'b1; wb_index = 3'd2; wb_tag = 9'h1FF;
        @(posedge clk); #2;
        wb_start = 1'b0;
        repeat (6) @(posedge clk);
        chk("ignore_count", obs.size(), 8);
        chk_beats("ignore", 0, 16'h5530, arr[3]);
        if (obs.size() > 0) chk("ignore_lit_data0", obs[0][15:0], 16'h30C5);

        // Asynchronous reset in the middle of beat 4.
        obs.delete();
        start_wb(3'd0, 9'h0AB);
        repeat (5) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("midrst_write", mem_write, 1'b0);
        chk("midrst_busy", wb_busy, 1'b0);
        chk("midrst_beats", obs.size(), 4);
        @(posedge clk); #2 reset_n = 1'b1;
        obs.delete();
        start_wb(3'd2, 9'h055);
        wait_done("after_rst", 40, n);
        chk("after_rst_latency", n, 10);
        chk("after_rst_count", obs.size(), 8);
        chk_beats("after_rst", 0, 16'h2AA0, arr[2]);

        // Back-to-back with wb_start held high.
        obs.delete();
        @(posedge clk); #2;
        wb_start = 1'b1; wb_index = 3'd1; wb_tag = 9'h0F0;
        @(posedge clk); #2;
        wb_index = 3'd6; wb_tag = 9'h1FF;
        wait_done("b2b_first", 40, n);
        chk("b2b_first_latency", n, 10);
        wait_done("b2b_second", 40, n2);
        wb_start = 1'b0;
        chk("b2b_gap", n2, 11);
        chk("b2b_count", obs.size(), 16);
        chk_beats("b2b_a", 0, 16'h7810, arr[1]);
        chk_beats("b2b_b", 8, 16'hFFE0, arr[6]);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
